// File: rtl/control_pkg.sv
// control_pkg: opcodes, field encodings and the control word shared by the decoder and its register
package control_pkg;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  typedef enum logic [1:0] {BR_NONE = 2'b00, BR_EQ = 2'b01, BR_NE = 2'b10, BR_GTZ = 2'b11} br_t;
  typedef enum logic [2:0] {ALU_ADD = 3'b000, ALU_SUB = 3'b001, ALU_RTYPE = 3'b010} alu_t;
  typedef struct packed {
    logic reg_dst;
    logic alu_src;
    logic mem_to_reg;
    logic reg_write;
    logic mem_write;
    logic ext_op;
    br_t  branch;
    alu_t alu_op;
  } ctrl_t;
  localparam ctrl_t CTRL_NOP = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, BR_NONE, ALU_ADD};
endpackage

// File: rtl/control_if.sv
// control_if: opcode and hazard requests in, registered control word out
interface control_if;
  logic       stall;
  logic       flush;
  logic [5:0] op;
  logic       RegDst;
  logic       ALUSrc;
  logic       MemtoReg;
  logic       RegWrite;
  logic       MemWrite;
  logic       ExtOp;
  logic [1:0] Branch;
  logic [2:0] ALUop;
  logic       illegal;
  modport master (output stall, flush, op,
                  input RegDst, ALUSrc, MemtoReg, RegWrite, MemWrite, ExtOp, Branch, ALUop, illegal);
  modport slave (input stall, flush, op,
                 output RegDst, ALUSrc, MemtoReg, RegWrite, MemWrite, ExtOp, Branch, ALUop, illegal);
endinterface

// File: rtl/control_decode.sv
// control_decode: combinational opcode to control word, flagging unknown opcodes
module control_decode
  import control_pkg::*;
(
  input  logic [5:0] op,
  output ctrl_t      ctrl,
  output logic       illegal
);
  // unknown opcodes fall through to the NOP word so they can never write or branch
  always_comb begin
    ctrl = CTRL_NOP;
    illegal = 1'b0;
    case (op)
      OP_RTYPE: ctrl = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, BR_NONE, ALU_RTYPE};
      OP_ADDI:  ctrl = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, BR_NONE, ALU_ADD};
      OP_LW:    ctrl = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, BR_NONE, ALU_ADD};
      OP_SW:    ctrl = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, BR_NONE, ALU_ADD};
      OP_BEQ:   ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, BR_EQ, ALU_SUB};
      OP_BNE:   ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, BR_NE, ALU_SUB};
      OP_BGTZ:  ctrl = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, BR_GTZ, ALU_SUB};
      default:  illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/control.sv
// control: main decoder with a stall/flush-aware output register feeding execute
module control
  import control_pkg::*;
(
  input  logic clk,
  input  logic reset,
  control_if.slave bus
);
  ctrl_t dec, ctrl_d, ctrl_q;
  logic  dec_illegal, illegal_d, illegal_q;
  control_decode u_decode (.op(bus.op), .ctrl(dec), .illegal(dec_illegal));
  // flush inserts a bubble and beats stall; stall holds the current word
  always_comb begin
    ctrl_d = bus.flush ? CTRL_NOP : bus.stall ? ctrl_q : dec;
    illegal_d = bus.flush ? 1'b0 : bus.stall ? illegal_q : dec_illegal;
  end
  // reset overrides every hazard request
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q <= CTRL_NOP;
      illegal_q <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      illegal_q <= illegal_d;
    end
  end
  assign bus.RegDst = ctrl_q.reg_dst;
  assign bus.ALUSrc = ctrl_q.alu_src;
  assign bus.MemtoReg = ctrl_q.mem_to_reg;
  assign bus.RegWrite = ctrl_q.reg_write;
  assign bus.MemWrite = ctrl_q.mem_write;
  assign bus.ExtOp = ctrl_q.ext_op;
  assign bus.Branch = ctrl_q.branch;
  assign bus.ALUop = ctrl_q.alu_op;
  assign bus.illegal = illegal_q;
endmodule

// File: tb/tb_control.sv
// tb_control: directed vectors against hand-computed control words
module tb_control;
  logic clk = 1'b0;
  logic reset;
  int   n_chk = 0;
  int   n_pass = 0;
  control_if bus ();
  control dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  // {illegal, RegDst, ALUSrc, MemtoReg, RegWrite, MemWrite, ExtOp, Branch, ALUop}
  localparam logic [11:0] W_NOP  = 12'b0_000000_00_000;
  localparam logic [11:0] W_R    = 12'b0_100100_00_010;
  localparam logic [11:0] W_ADDI = 12'b0_010101_00_000;
  localparam logic [11:0] W_LW   = 12'b0_011101_00_000;
  localparam logic [11:0] W_SW   = 12'b0_010011_00_000;
  localparam logic [11:0] W_BEQ  = 12'b0_000001_01_001;
  localparam logic [11:0] W_BNE  = 12'b0_000001_10_001;
  localparam logic [11:0] W_BGTZ = 12'b0_000001_11_001;
  localparam logic [11:0] W_ILL  = 12'b1_000000_00_000;
  logic [11:0] obs;
  assign obs = {bus.illegal, bus.RegDst, bus.ALUSrc, bus.MemtoReg, bus.RegWrite,
                bus.MemWrite, bus.ExtOp, bus.Branch, bus.ALUop};
  task automatic chk(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got %b exp %b", tag, got, exp);
  endtask
  task automatic cyc(input logic [5:0] op, input logic st, input logic fl, input logic rs,
                     input string tag, input logic [11:0] exp);
    bus.op = op;
    bus.stall = st;
    bus.flush = fl;
    reset = rs;
    @(posedge clk);
    #1;
    chk(tag, obs, exp);
  endtask
  typedef struct {logic [5:0] op; logic [11:0] exp; string tag;} vec_t;
  vec_t sweep[8];
  initial begin
    sweep[0] = '{6'b000000, W_R, "sw_r"};
    sweep[1] = '{6'b001000, W_ADDI, "sw_addi"};
    sweep[2] = '{6'b100011, W_LW, "sw_lw"};
    sweep[3] = '{6'b101011, W_SW, "sw_sw"};
    sweep[4] = '{6'b000100, W_BEQ, "sw_beq"};
    sweep[5] = '{6'b000101, W_BNE, "sw_bne"};
    sweep[6] = '{6'b000111, W_BGTZ, "sw_bgtz"};
    sweep[7] = '{6'b000000, W_R, "sw_r2"};
    cyc(6'b000000, 1'b0, 1'b0, 1'b1, "rst0", W_NOP);
    cyc(6'b000000, 1'b0, 1'b0, 1'b1, "rst1", W_NOP);
    cyc(6'b000000, 1'b0, 1'b0, 1'b0, "rst_rel", W_R);
    foreach (sweep[i]) cyc(sweep[i].op, 1'b0, 1'b0, 1'b0, sweep[i].tag, sweep[i].exp);
    cyc(6'b111111, 1'b0, 1'b0, 1'b0, "ill", W_ILL);
    cyc(6'b010000, 1'b0, 1'b0, 1'b0, "ill2", W_ILL);
    cyc(6'b001000, 1'b0, 1'b0, 1'b0, "ill_clr", W_ADDI);
    cyc(6'b111111, 1'b0, 1'b0, 1'b0, "ill3", W_ILL);
    cyc(6'b001000, 1'b0, 1'b1, 1'b0, "fl_ill", W_NOP);
    cyc(6'b101011, 1'b0, 1'b0, 1'b0, "st_sw", W_SW);
    for (int i = 0; i < 3; i++) cyc(6'b100011, 1'b1, 1'b0, 1'b0, "st_hold", W_SW);
    cyc(6'b100011, 1'b0, 1'b0, 1'b0, "st_rel", W_LW);
    cyc(6'b000100, 1'b0, 1'b1, 1'b0, "fl_beq", W_NOP);
    cyc(6'b000100, 1'b0, 1'b0, 1'b0, "beq", W_BEQ);
    cyc(6'b000100, 1'b1, 1'b1, 1'b0, "fl_st", W_NOP);
    cyc(6'b000111, 1'b1, 1'b0, 1'b0, "st_nop", W_NOP);
    cyc(6'b000000, 1'b0, 1'b0, 1'b0, "r_again", W_R);
    cyc(6'b100011, 1'b1, 1'b0, 1'b0, "st_r", W_R);
    cyc(6'b100011, 1'b1, 1'b0, 1'b1, "rst_st", W_NOP);
    cyc(6'b000000, 1'b0, 1'b0, 1'b1, "rst_hold", W_NOP);
    cyc(6'b101011, 1'b0, 1'b0, 1'b0, "post_rst", W_SW);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
